// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX/MEM-side inputs and MEM/WB-side outputs of the memory stage
interface mem_stage_if;
  logic        in_valid;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToReg;
  logic        RegWrite;
  logic        mem_byte;
  logic        mem_unsigned;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  write_reg;
  logic        stall;
  logic        MemToReg_out;
  logic        RegWrite_out;
  logic [31:0] mem_read_data;
  logic [31:0] alu_result_out;
  logic [4:0]  write_reg_out;
  logic        misaligned;

  modport slave (
    input  in_valid, MemRead, MemWrite, MemToReg, RegWrite, mem_byte, mem_unsigned,
    input  alu_result, write_data, write_reg,
    output stall, MemToReg_out, RegWrite_out, mem_read_data, alu_result_out,
    output write_reg_out, misaligned
  );

  modport master (
    output in_valid, MemRead, MemWrite, MemToReg, RegWrite, mem_byte, mem_unsigned,
    output alu_result, write_data, write_reg,
    input  stall, MemToReg_out, RegWrite_out, mem_read_data, alu_result_out,
    input  write_reg_out, misaligned
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: byte-lane data RAM with wait states and stall
module mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        rd_q, wr_q, m2r_q, rw_q, byte_q, uns_q, mis_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [4:0]  wreg_q;

  logic [31:0] ram [DEPTH_WORDS];

  logic          mem_op, in_mis, access;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   ram_word, ld_data;
  logic [7:0]    lane_byte;

  assign mem_op   = bus.in_valid & (bus.MemRead | bus.MemWrite);
  assign in_mis   = ~bus.mem_byte & (|bus.alu_result[1:0]);
  assign idx      = addr_q[AW+1:2];
  assign lane     = addr_q[1:0];
  assign access   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign ram_word = ram[idx];

  always_comb begin
    lane_byte = 8'h00;
    case (lane)
      2'd0:    lane_byte = ram_word[7:0];
      2'd1:    lane_byte = ram_word[15:8];
      2'd2:    lane_byte = ram_word[23:16];
      default: lane_byte = ram_word[31:24];
    endcase
    if (!byte_q)
      ld_data = ram_word;
    else if (uns_q)
      ld_data = {24'h000000, lane_byte};
    else
      ld_data = {{24{lane_byte[7]}}, lane_byte};
  end

  // Reset gates the write so an in-flight store is dropped; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && access && wr_q && !mis_q) begin
      for (int b = 0; b < 4; b++) begin
        if (!byte_q)
          ram[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        else if (lane == 2'(b))
          ram[idx][8*b +: 8] <= wdata_q[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      byte_q  <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wreg_q  <= 5'h0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            rd_q    <= bus.MemRead;
            wr_q    <= bus.MemWrite;
            m2r_q   <= bus.MemToReg;
            rw_q    <= bus.RegWrite;
            byte_q  <= bus.mem_byte;
            uns_q   <= bus.mem_unsigned;
            mis_q   <= in_mis;
            addr_q  <= bus.alu_result;
            wdata_q <= bus.write_data;
            wreg_q  <= bus.write_reg;
            rdata_q <= 32'h0;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // Read-and-write together behaves as a store, so no load data.
            rdata_q <= (rd_q && !wr_q && !mis_q) ? ld_data : 32'h0;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.stall          = 1'b0;
    bus.MemToReg_out   = 1'b0;
    bus.RegWrite_out   = 1'b0;
    bus.mem_read_data  = 32'h0;
    bus.alu_result_out = 32'h0;
    bus.write_reg_out  = 5'h0;
    bus.misaligned     = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          bus.stall = mem_op;
          if (bus.in_valid && !mem_op) begin
            bus.MemToReg_out   = bus.MemToReg;
            bus.RegWrite_out   = bus.RegWrite;
            bus.alu_result_out = bus.alu_result;
            bus.write_reg_out  = bus.write_reg;
          end
        end
        ACCESS: bus.stall = 1'b1;
        DONE: begin
          bus.MemToReg_out   = m2r_q & ~mis_q;
          bus.RegWrite_out   = rw_q & ~mis_q & ~(rd_q & wr_q);
          bus.mem_read_data  = rdata_q;
          bus.alu_result_out = addr_q;
          bus.write_reg_out  = wreg_q;
          bus.misaligned     = mis_q;
        end
        default: bus.stall = 1'b0;
      endcase
    end
  end
endmodule
